// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM encoding, port indices and default timeout for cache_arb.
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} arb_state_e;
    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;
    localparam int DEF_TIMEOUT_CYCLES = 64;
endpackage

// File: rtl/cache_arb_if.sv
// cache_arb_if: instruction/data request-response bundle plus the shared cache controller bus.
interface cache_arb_if;
    logic        i_rd, i_done, i_err, i_stall;
    logic [15:0] i_addr, i_data_out;
    logic        d_rd, d_wr, d_done, d_hit, d_err, d_stall;
    logic [15:0] d_addr, d_data_in, d_data_out;
    logic        c_rd, c_wr, c_done, c_cachehit, c_err;
    logic [15:0] c_addr, c_data_in, c_data_out;
    modport slave (
        input  i_rd, i_addr, d_rd, d_wr, d_addr, d_data_in, c_done, c_data_out, c_cachehit, c_err,
        output i_done, i_data_out, i_err, i_stall, d_done, d_data_out, d_hit, d_err, d_stall,
               c_rd, c_wr, c_addr, c_data_in
    );
    modport master (
        output i_rd, i_addr, d_rd, d_wr, d_addr, d_data_in, c_done, c_data_out, c_cachehit, c_err,
        input  i_done, i_data_out, i_err, i_stall, d_done, d_data_out, d_hit, d_err, d_stall,
               c_rd, c_wr, c_addr, c_data_in
    );
endinterface

// File: rtl/cache_arb_rr_grant2.sv
// rr_grant2: two-way round-robin grant; on a tie the port not granted last wins.
module rr_grant2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);
    always_comb gnt = (&req) ? ((last == PORT_D) ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/cache_arb.sv
// cache_arb: shares one cache controller between instruction and data ports.
// Optional ARB_TIMEOUT_EN aborts an access after TIMEOUT_CYCLES busy cycles with err=1.
module cache_arb
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    cache_arb_if.slave bus
);
    arb_state_e  state, state_nxt;
    logic [1:0]  req, gnt;
    logic        last_q, wr_q, hit_q, err_q;
    logic        busy, resp, fin, tmo, c_wr;
    logic [15:0] addr_q, wdata_q, i_data_q, d_data_q, rdata;

    assign req = {bus.d_rd | bus.d_wr, bus.i_rd};

    rr_grant2 u_rr (.req(req), .last(last_q), .gnt(gnt));

    assign busy  = (state == BUSY_I) || (state == BUSY_D);
    assign resp  = (state == RESP);
    assign fin   = busy && (bus.c_done || tmo);
    assign rdata = bus.c_done ? bus.c_data_out : '0;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else cnt <= busy ? cnt + CNT_W'(1) : '0;
    assign tmo = busy && (cnt == CNT_W'(TIMEOUT_CYCLES));
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;

    always_comb begin
        state_nxt = state;
        if (state == IDLE) state_nxt = gnt[PORT_D] ? BUSY_D : gnt[PORT_I] ? BUSY_I : IDLE;
        else if (busy) state_nxt = fin ? RESP : state;
        else state_nxt = IDLE;
    end

    // last_q doubles as the owner of the access in flight and the round-robin pointer
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            last_q   <= PORT_I;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            hit_q    <= 1'b0;
            err_q    <= 1'b0;
            i_data_q <= '0;
            d_data_q <= '0;
        end else begin
            if (state == IDLE && |req) begin
                last_q  <= gnt[PORT_D] ? PORT_D : PORT_I;
                wr_q    <= gnt[PORT_D] & bus.d_wr;
                addr_q  <= gnt[PORT_D] ? bus.d_addr : bus.i_addr;
                wdata_q <= gnt[PORT_D] ? bus.d_data_in : '0;
            end
            if (fin) begin
                hit_q <= bus.c_done & bus.c_cachehit;
                err_q <= bus.c_done ? bus.c_err : 1'b1;
                if (last_q == PORT_D) d_data_q <= rdata;
                else i_data_q <= rdata;
            end
        end

    assign c_wr          = busy & wr_q;
    assign bus.c_wr      = c_wr;
    assign bus.c_rd      = busy & ~wr_q;
    assign bus.c_addr    = busy ? addr_q : '0;
    assign bus.c_data_in = c_wr ? wdata_q : '0;

    assign bus.i_done     = resp && (last_q == PORT_I);
    assign bus.d_done     = resp && (last_q == PORT_D);
    assign bus.i_data_out = i_data_q;
    assign bus.d_data_out = d_data_q;
    assign bus.i_err      = bus.i_done & err_q;
    assign bus.d_err      = bus.d_done & err_q;
    assign bus.d_hit      = bus.d_done & hit_q;
    assign bus.i_stall    = rst_n & bus.i_rd & ~bus.i_done;
    assign bus.d_stall    = rst_n & (bus.d_rd | bus.d_wr) & ~bus.d_done;
endmodule
